// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the data-RAM port arbiter.
//   DATA_ROW_WIDTH       default RAM row width
//   DATA_ADDRESS_WIDTH   default RAM address width
//   ARB_NUM_REQUESTERS   default number of requesters sharing the RAM
//   nxt_ptr()            cyclic successor of a requester index
package ram_port_arbiter_pkg;

   localparam int DATA_ROW_WIDTH     = 32;
   localparam int DATA_ADDRESS_WIDTH = 10;
   localparam int ARB_NUM_REQUESTERS = 4;

   // Explicit modulo so non-power-of-2 requester counts wrap correctly.
   function automatic int unsigned nxt_ptr(input int unsigned idx, input int unsigned n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin finder.
//   req_i    request vector
//   start_i  index searched first; search proceeds cyclically upward
//   excl_i   requesters that may not win
//   grant_o  one-hot winner (zero when nothing qualifies)
//   found_o  a winner exists
//   idx_o    binary index of the winner (0 when none)
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] start_i,
   input  logic [N-1:0]  excl_i,
   output logic [N-1:0]  grant_o,
   output logic          found_o,
   output logic [PW-1:0] idx_o
);

   always_comb begin
      logic [PW-1:0] pos;
      pos     = '0;
      grant_o = '0;
      found_o = 1'b0;
      idx_o   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pos = PW'((32'(start_i) + i) % N);
         if (!found_o && req_i[pos] && !excl_i[pos]) begin
            found_o      = 1'b1;
            grant_o[pos] = 1'b1;
            idx_o        = pos;
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one 2-read/1-write data RAM among NREQ requesters.
//   Clock, Reset                     single clock, synchronous active-high reset
//   iReadRequest/iReadAddress        per-requester read requests (held until granted)
//   oReadGrant                       combinational read grants (0..2 bits set)
//   oReadDataValid/oReadData         per-requester registered read return, grant+2
//   iWriteRequest/iWriteAddress/iWriteData  per-requester write requests
//   oWriteGrant                      combinational one-hot write grant
//   oRamWriteEnable/oRamWriteAddress/oRamDataIn  RAM write port
//   oRamReadAddress0/1, iRamDataOut0/1           RAM read ports (1-cycle latency)
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_ROW_WIDTH,
   parameter int ADDR_WIDTH = DATA_ADDRESS_WIDTH,
   parameter int NREQ       = ARB_NUM_REQUESTERS
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic [NREQ-1:0]            iReadRequest,
   input  logic [NREQ*ADDR_WIDTH-1:0] iReadAddress,
   output logic [NREQ-1:0]            oReadGrant,
   output logic [NREQ-1:0]            oReadDataValid,
   output logic [NREQ*DATA_WIDTH-1:0] oReadData,
   input  logic [NREQ-1:0]            iWriteRequest,
   input  logic [NREQ*ADDR_WIDTH-1:0] iWriteAddress,
   input  logic [NREQ*DATA_WIDTH-1:0] iWriteData,
   output logic [NREQ-1:0]            oWriteGrant,
   output logic                       oRamWriteEnable,
   output logic [ADDR_WIDTH-1:0]      oRamWriteAddress,
   output logic [DATA_WIDTH-1:0]      oRamDataIn,
   output logic [ADDR_WIDTH-1:0]      oRamReadAddress0,
   output logic [ADDR_WIDTH-1:0]      oRamReadAddress1,
   input  logic [DATA_WIDTH-1:0]      iRamDataOut0,
   input  logic [DATA_WIDTH-1:0]      iRamDataOut1
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [1:0]            tag_vld_q, tag_vld_d;
   logic [PW-1:0]         tag_idx_q [2];
   logic [PW-1:0]         tag_idx_d [2];
   logic [DATA_WIDTH-1:0] rdata_q [NREQ];
   logic [DATA_WIDTH-1:0] rdata_d [NREQ];
   logic [NREQ-1:0]       rvalid_q, rvalid_d;

   logic [NREQ-1:0] rd_req, wr_req, g0, g1, wg;
   logic            f0, f1, wf;
   logic [PW-1:0]   i0, i1, wi, p1_start;

   // Requests are masked during reset so every grant and the write enable drop.
   assign rd_req   = Reset ? '0 : iReadRequest;
   assign wr_req   = Reset ? '0 : iWriteRequest;
   assign p1_start = PW'(nxt_ptr(32'(i0), NREQ));

   rr_pick #(.N(NREQ), .PW(PW)) u_pick_rd0 (
      .req_i(rd_req), .start_i(rd_ptr_q), .excl_i('0),
      .grant_o(g0), .found_o(f0), .idx_o(i0));

   rr_pick #(.N(NREQ), .PW(PW)) u_pick_rd1 (
      .req_i(rd_req), .start_i(p1_start), .excl_i(g0),
      .grant_o(g1), .found_o(f1), .idx_o(i1));

   rr_pick #(.N(NREQ), .PW(PW)) u_pick_wr (
      .req_i(wr_req), .start_i(wr_ptr_q), .excl_i('0),
      .grant_o(wg), .found_o(wf), .idx_o(wi));

   assign oReadGrant      = g0 | g1;
   assign oWriteGrant     = wg;
   assign oRamWriteEnable = wf;
   assign oReadDataValid  = rvalid_q;

   always_comb begin
      oRamReadAddress0 = '0;
      oRamReadAddress1 = '0;
      oRamWriteAddress = '0;
      oRamDataIn       = '0;
      if (f0) oRamReadAddress0 = iReadAddress[32'(i0)*ADDR_WIDTH +: ADDR_WIDTH];
      if (f1) oRamReadAddress1 = iReadAddress[32'(i1)*ADDR_WIDTH +: ADDR_WIDTH];
      if (wf) begin
         oRamWriteAddress = iWriteAddress[32'(wi)*ADDR_WIDTH +: ADDR_WIDTH];
         oRamDataIn       = iWriteData[32'(wi)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < NREQ; k++) begin
         oReadData[k*DATA_WIDTH +: DATA_WIDTH] = rdata_q[k];
      end
   end

   always_comb begin
      // Port 1 always wins cyclically after port 0, so it is the last granted.
      rd_ptr_d = rd_ptr_q;
      if (f1)      rd_ptr_d = PW'(nxt_ptr(32'(i1), NREQ));
      else if (f0) rd_ptr_d = PW'(nxt_ptr(32'(i0), NREQ));
      wr_ptr_d = wr_ptr_q;
      if (wf) wr_ptr_d = PW'(nxt_ptr(32'(wi), NREQ));

      tag_vld_d    = {f1, f0};
      tag_idx_d[0] = i0;
      tag_idx_d[1] = i1;

      // The two tags never name the same requester, so the writes cannot collide.
      rdata_d  = rdata_q;
      rvalid_d = '0;
      if (tag_vld_q[0]) begin
         rdata_d[tag_idx_q[0]]  = iRamDataOut0;
         rvalid_d[tag_idx_q[0]] = 1'b1;
      end
      if (tag_vld_q[1]) begin
         rdata_d[tag_idx_q[1]]  = iRamDataOut1;
         rvalid_d[tag_idx_q[1]] = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         tag_vld_q    <= '0;
         tag_idx_q[0] <= '0;
         tag_idx_q[1] <= '0;
         rvalid_q     <= '0;
         for (int unsigned k = 0; k < NREQ; k++) rdata_q[k] <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         tag_vld_q <= tag_vld_d;
         tag_idx_q <= tag_idx_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

   localparam int DW = 16;
   localparam int AW = 6;
   localparam int NR = 4;

   logic            Clock = 1'b0;
   logic            Reset;
   logic [NR-1:0]   rreq, rgnt, rvld, wreq, wgnt;
   logic [NR*AW-1:0] raddr_f, waddr_f;
   logic [NR*DW-1:0] rdata_f, wdata_f;
   logic            ram_we;
   logic [AW-1:0]   ram_wa, ram_ra0, ram_ra1;
   logic [DW-1:0]   ram_din, ram_dout0, ram_dout1;

   logic [AW-1:0] ra [NR];
   logic [AW-1:0] wa [NR];
   logic [DW-1:0] wd [NR];

   always_comb begin
      for (int k = 0; k < NR; k++) begin
         raddr_f[k*AW +: AW] = ra[k];
         waddr_f[k*AW +: AW] = wa[k];
         wdata_f[k*DW +: DW] = wd[k];
      end
   end

   ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NREQ(NR)) dut (
      .Clock(Clock), .Reset(Reset),
      .iReadRequest(rreq), .iReadAddress(raddr_f), .oReadGrant(rgnt),
      .oReadDataValid(rvld), .oReadData(rdata_f),
      .iWriteRequest(wreq), .iWriteAddress(waddr_f), .iWriteData(wdata_f),
      .oWriteGrant(wgnt), .oRamWriteEnable(ram_we), .oRamWriteAddress(ram_wa),
      .oRamDataIn(ram_din), .oRamReadAddress0(ram_ra0), .oRamReadAddress1(ram_ra1),
      .iRamDataOut0(ram_dout0), .iRamDataOut1(ram_dout1));

   always #5 Clock = ~Clock;

   // Read-before-write RAM model with registered outputs.
   logic [DW-1:0] mem [2**AW];
   initial for (int i = 0; i < 2**AW; i++) mem[i] = '0;
   always @(posedge Clock) begin
      ram_dout0 <= mem[ram_ra0];
      ram_dout1 <= mem[ram_ra1];
      if (ram_we) mem[ram_wa] <= ram_din;
   end

   int cyc = 0;
   always @(posedge Clock) cyc = cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t exq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every valid pulse must match the oldest outstanding read.
   always @(negedge Clock) begin
      while (exq.size() > 0 && exq[0].due < cyc) begin
         checks++; failures++;
         $display("FAIL missing_valid: req %0d got none expected data %0h at cycle %0d",
                  exq[0].idx, exq[0].data, exq[0].due);
         void'(exq.pop_front());
      end
      for (int k = 0; k < NR; k++) begin
         if (rvld[k]) begin
            if (exq.size() == 0 || exq[0].due != cyc || exq[0].idx != k) begin
               checks++; failures++;
               $display("FAIL unexpected_valid: req %0d got valid expected none (cycle %0d)", k, cyc);
            end else begin
               chk($sformatf("rdata_req%0d", k), 64'(rdata_f[k*DW +: DW]), 64'(exq[0].data));
               void'(exq.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic clear_req();
      rreq = '0;
      wreq = '0;
   endtask

   task automatic exp_rd(input int idx, input logic [DW-1:0] data);
      exq.push_back('{idx: idx, data: data, due: cyc + 2});
   endtask

   task automatic do_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      step(); clear_req();
      wreq[k] = 1'b1; wa[k] = a; wd[k] = d;
      #1;
      chk("wr_grant", 64'(wgnt), 64'(4'b1 << k));
      chk("wr_en", 64'(ram_we), 64'd1);
      chk("wr_addr", 64'(ram_wa), 64'(a));
      chk("wr_data", 64'(ram_din), 64'(d));
   endtask

   initial begin
      Reset = 1'b1;
      rreq = '1; wreq = '1;
      for (int k = 0; k < NR; k++) begin ra[k] = '0; wa[k] = '0; wd[k] = '0; end
      repeat (2) step();
      #1;
      chk("rst_rgrant", 64'(rgnt), 64'd0);
      chk("rst_wgrant", 64'(wgnt), 64'd0);
      chk("rst_we", 64'(ram_we), 64'd0);

      // Idle after reset
      step(); Reset = 1'b0; clear_req();
      #1;
      chk("idle_rgrant", 64'(rgnt), 64'd0);
      chk("idle_wgrant", 64'(wgnt), 64'd0);
      chk("idle_we", 64'(ram_we), 64'd0);
      chk("idle_rvalid", 64'(rvld), 64'd0);
      chk("idle_rdata", 64'(rdata_f), 64'd0);

      // Requester 2 writes 0xA5 to 7, requester 0 reads it next cycle
      do_write(2, 6'd7, 16'h00A5);
      step(); clear_req();
      rreq[0] = 1'b1; ra[0] = 6'd7;
      #1;
      chk("rd7_grant", 64'(rgnt), 64'b0001);
      chk("rd7_addr0", 64'(ram_ra0), 64'd7);
      chk("rd7_addr1_idle", 64'(ram_ra1), 64'd0);
      exp_rd(0, 16'h00A5);

      // Preload addresses 10..13
      for (int k = 0; k < NR; k++) do_write(k, 6'(10 + k), 16'(16'h0100 + k));

      // Reset pointers, then all four read from RdPtr=0
      step(); clear_req(); Reset = 1'b1;
      step(); Reset = 1'b0;
      rreq = 4'b1111;
      for (int k = 0; k < NR; k++) ra[k] = 6'(10 + k);
      #1;
      chk("all4_c1_grant", 64'(rgnt), 64'b0011);
      chk("all4_c1_a0", 64'(ram_ra0), 64'd10);
      chk("all4_c1_a1", 64'(ram_ra1), 64'd11);
      exp_rd(0, 16'h0100); exp_rd(1, 16'h0101);
      step(); rreq = 4'b1100;
      #1;
      chk("all4_c2_grant", 64'(rgnt), 64'b1100);
      chk("all4_c2_a0", 64'(ram_ra0), 64'd12);
      chk("all4_c2_a1", 64'(ram_ra1), 64'd13);
      exp_rd(2, 16'h0102); exp_rd(3, 16'h0103);

      // Requester 0 back-to-back pipelined reads
      step(); clear_req(); rreq[0] = 1'b1; ra[0] = 6'd10;
      #1;
      chk("pipe_c1_grant", 64'(rgnt), 64'b0001);
      exp_rd(0, 16'h0100);
      step(); ra[0] = 6'd11;
      #1;
      chk("pipe_c2_grant", 64'(rgnt), 64'b0001);
      chk("pipe_c2_a0", 64'(ram_ra0), 64'd11);
      exp_rd(0, 16'h0101);

      // Requesters 1 and 3 hold writes: 1,3,1,3
      step(); clear_req();
      wreq = 4'b1010;
      wa[1] = 6'd20; wd[1] = 16'h0021;
      wa[3] = 6'd30; wd[3] = 16'h0033;
      for (int n = 0; n < 4; n++) begin
         if (n > 0) step();
         #1;
         chk($sformatf("wr_alt_%0d", n), 64'(wgnt), (n % 2 == 0) ? 64'b0010 : 64'b1000);
         chk($sformatf("wr_alt_addr_%0d", n), 64'(ram_wa), (n % 2 == 0) ? 64'd20 : 64'd30);
      end

      // Same-cycle read and write of address 5 returns old data
      do_write(0, 6'd5, 16'h0011);
      step(); clear_req();
      wreq[1] = 1'b1; wa[1] = 6'd5; wd[1] = 16'h0022;
      rreq[2] = 1'b1; ra[2] = 6'd5;
      #1;
      chk("rw_same_wgrant", 64'(wgnt), 64'b0010);
      chk("rw_same_rgrant", 64'(rgnt), 64'b0100);
      exp_rd(2, 16'h0011);
      step(); clear_req(); rreq[2] = 1'b1;
      #1;
      chk("rw_after_rgrant", 64'(rgnt), 64'b0100);
      exp_rd(2, 16'h0022);

      // Two-port read granted, then reset: those reads must never return
      step(); clear_req();
      rreq = 4'b1001; ra[0] = 6'd20; ra[3] = 6'd30;
      #1;
      chk("rst_pre_grant", 64'(rgnt), 64'b1001);
      step(); Reset = 1'b1; rreq = '1; wreq = '1;
      #1;
      chk("rst_mid_rgrant", 64'(rgnt), 64'd0);
      chk("rst_mid_wgrant", 64'(wgnt), 64'd0);
      chk("rst_mid_we", 64'(ram_we), 64'd0);
      step(); Reset = 1'b0; clear_req();
      repeat (2) step();

      // Pointers are back at 0
      rreq = 4'b1111;
      ra[0] = 6'd20; ra[1] = 6'd30; ra[2] = 6'd5; ra[3] = 6'd7;
      wreq = 4'b1010;
      wa[1] = 6'd40; wd[1] = 16'h0044;
      wa[3] = 6'd41; wd[3] = 16'h0055;
      #1;
      chk("post_rst_rgrant", 64'(rgnt), 64'b0011);
      chk("post_rst_wgrant", 64'(wgnt), 64'b0010);
      chk("post_rst_a0", 64'(ram_ra0), 64'd20);
      exp_rd(0, 16'h0021); exp_rd(1, 16'h0033);
      step(); rreq = 4'b1100; wreq = '0;
      #1;
      chk("post_rst_rgrant2", 64'(rgnt), 64'b1100);
      exp_rd(2, 16'h0022); exp_rd(3, 16'h00A5);
      step(); clear_req();

      repeat (5) step();
      chk("scoreboard_drained", 64'(exq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
